regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
Debug/read-out engine on a spare register-file read port. On a start command it walks a contiguous, wrap-capable range of register indices and drives the read address. It captures each combinational read value and streams (index, data) pairs to a consumer over a valid/ready handshake. Used by the debug/trace path to dump architectural state without stalling the core's write port.

Parameters:
REGISTERS, 32, number of registers in the target file; power of two, >= 2
WIDTH, 32, register data width in bits
AW, $clog2(REGISTERS), derived address width; not overridden by users

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
abort  input  1  terminate an active dump at the next edge
first_idx  input  AW  first register index of range, latched on accepted start
last_idx  input  AW  last register index of range, inclusive, latched on accepted start
rf_addr  output  AW  read address to register-file read port (registered)
rf_data  input  WIDTH  combinational read data for rf_addr
out_valid  output  1  out_idx/out_data hold a valid pair
out_ready  input  1  consumer accepts pair when out_valid && out_ready
out_idx  output  AW  register index of current pair
out_data  output  WIDTH  register value of current pair
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last pair is accepted or after abort

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. rf_addr, out_idx, out_data, remaining count are all 0. out_valid, busy and done are 0. Reset overrides everything, including a mid-dump state and a pending out_valid.
- Range length is N = ((last_idx - first_idx) mod REGISTERS) + 1, from 1 to REGISTERS.
  - first_idx > last_idx wraps: first..REGISTERS-1, then 0..last.
  - first_idx == last_idx gives exactly 1 pair.
  - To dump the full file, use last = first-1 (mod REGISTERS).
- The remaining counter is AW+1 bits wide. Address increment wraps REGISTERS-1 -> 0.
- States:
  - IDLE. On start=1: rf_addr<=first_idx, remaining<=N, go to FETCH. Otherwise hold. start is ignored outside IDLE.
  - FETCH (1 cycle). out_data<=rf_data, out_idx<=rf_addr, out_valid<=1, go to SEND.
  - SEND. Wait for out_ready.
    - While out_valid && !out_ready: out_idx and out_data stay stable.
    - On the handshake with remaining==1: out_valid<=0, done<=1, go to IDLE.
    - On the handshake with remaining>1: remaining<=remaining-1, rf_addr<=rf_addr+1 (wrap), out_valid<=0, go to FETCH.
- Throughput: at most one pair per 2 cycles. Latency from start to first out_valid is 2 edges.
- Snapshot semantics: each pair carries the rf_data value sampled at that pair's FETCH edge. Register writes after that edge are not reflected in the pair.
- abort=1 in FETCH or SEND: next edge sets out_valid<=0, done<=1, goes to IDLE, and no further pairs are issued. abort takes priority over a simultaneous handshake; that pair counts as not delivered. abort in IDLE has no effect and no done pulse.
- done is high for exactly one cycle and is never asserted in the same cycle as out_valid.
- Index 0 is not special-cased here; its value is whatever the register file returns (0 for x0).

Test Plan:
- Reset mid-dump: start range 2..9, assert rst while in SEND -> next cycle out_valid=0, busy=0, done=0, rf_addr=0; a new start is accepted normally afterwards.
- Basic range: preload rN=0x100+N, start first=3 last=6, out_ready=1 -> exactly 4 pairs (3,0x103)..(6,0x106) in order, each 2 cycles apart; done pulses once in the cycle after the last handshake; busy drops in the same cycle as the done pulse.
- Wrap-around: first=30 last=1, REGISTERS=32 -> pairs at idx 30,31,0,1; idx 0 data=0; total 4; done once.
- Full file and single entry: first=5 last=4 gives 32 pairs, idx 5..31 then 0..4. first=last=7 gives exactly 1 pair (7,0x107).
- Backpressure and snapshot: hold out_ready=0 for 5 cycles on the pair for r3 while the core writes r3=0xDEAD -> out_data stays at the captured 0x103 throughout; the next pair (r4) is issued only after the handshake.
- Abort and ignored start: start 0..31, abort at the third SEND with out_ready=1 in the same cycle -> 2 pairs delivered, done pulses once, no further out_valid. A start pulse while busy is ignored (pair count unchanged). abort in IDLE produces no done pulse.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying (register index, register value) pairs from
// the dump reader to its consumer.
interface regfile_dump_reader_if #(
    parameter int AW    = 5,
    parameter int WIDTH = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_idx;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks a wrap-capable index range on a spare read
// port, snapshots each combinational read value and streams (index, data)
// pairs over a valid/ready handshake.
module regfile_dump_reader #(
    parameter int  REGISTERS = 32,
    parameter int  WIDTH     = 32,
    localparam int AW        = $clog2(REGISTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [AW-1:0]          first_idx_i,
    input  logic [AW-1:0]          last_idx_i,
    output logic [AW-1:0]          rf_addr_o,
    input  logic [WIDTH-1:0]       rf_data_i,
    regfile_dump_reader_if.master  out,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [AW-1:0]    rf_addr_q,   rf_addr_d;
    logic [AW-1:0]    out_idx_q,   out_idx_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [AW:0]      remaining_q, remaining_d;
    logic             done_q,      done_d;

    logic [AW-1:0]    range_diff;
    logic [AW:0]      range_len;
    logic             handshake;

    // Range length: the AW-bit difference wraps modulo REGISTERS, so a full
    // file (last = first-1) yields REGISTERS, which needs the extra bit.
    assign range_diff = last_idx_i - first_idx_i;
    assign range_len  = {1'b0, range_diff} + {{AW{1'b0}}, 1'b1};
    assign handshake  = out_valid_q && out.out_ready;

    // Next-state logic for the IDLE -> FETCH -> SEND walk.
    always_comb begin
        state_d     = state_q;
        rf_addr_d   = rf_addr_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rf_addr_d   = first_idx_i;
                    remaining_d = range_len;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort_i) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    out_data_d  = rf_data_i;
                    out_idx_d   = rf_addr_q;
                    out_valid_d = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                // abort wins over a simultaneous handshake; that pair is dropped
                if (abort_i) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else if (handshake) begin
                    out_valid_d = 1'b0;
                    if (remaining_q == {{AW{1'b0}}, 1'b1}) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        remaining_d = remaining_q - {{AW{1'b0}}, 1'b1};
                        rf_addr_d   = rf_addr_q + {{(AW-1){1'b0}}, 1'b1};
                        state_d     = S_FETCH;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset overriding any dump in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rf_addr_q   <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_addr_q   <= rf_addr_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    assign rf_addr_o     = rf_addr_q;
    assign out.out_valid = out_valid_q;
    assign out.out_idx   = out_idx_q;
    assign out.out_data  = out_data_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;

endmodule
